// File: rtl/lsu_line_mem.sv
// Line-granular backing memory behind the L2 cache: valid/ready request and
// response handshake, fixed access latency, per-word write masks and peripheral I/O.
module lsu_line_mem #(
   parameter int unsigned LINE_WORDS  = 4,
   parameter int unsigned MEM_WORDS   = 512,
   parameter int unsigned LATENCY     = 4,
   parameter int unsigned IO_OUT_BASE = 256,
   parameter int unsigned IO_IN_BASE  = 320,
   parameter int unsigned IO_IN_END   = 384,
   parameter int unsigned NUM_IO_OUT  = 11
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         req_valid_i,
   output logic                         req_ready_o,
   input  logic                         req_we_i,
   input  logic [31:0]                  req_addr_i,
   input  logic [32*LINE_WORDS-1:0]     req_wdata_i,
   input  logic [LINE_WORDS-1:0]        req_wmask_i,
   output logic                         rsp_valid_o,
   input  logic                         rsp_ready_i,
   output logic [32*LINE_WORDS-1:0]     rsp_data_o,
   output logic                         rsp_err_o,
   input  logic [31:0]                  io_sw_i,
   output logic [32*NUM_IO_OUT-1:0]     io_out_o
);

   localparam int unsigned AW = $clog2(MEM_WORDS);
   localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int unsigned OW = (NUM_IO_OUT > 1) ? $clog2(NUM_IO_OUT) : 1;
   localparam logic [31:0] ALIGN_MASK = ~32'(LINE_WORDS - 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

   state_e                    state_q, state_d;
   logic [CW-1:0]             cnt_q;
   logic                      we_q;
   logic [31:0]               base_q;
   logic [32*LINE_WORDS-1:0]  wdata_q;
   logic [LINE_WORDS-1:0]     wmask_q;
   logic [32*LINE_WORDS-1:0]  rsp_data_q;
   logic                      rsp_err_q;
   logic [31:0]               io_out_q [NUM_IO_OUT];
   logic [31:0]               mem [MEM_WORDS];
   logic [31:0]               sw_meta_q, sw_sync_q;

   logic                      accept, access, in_range, wr_err;
   logic [31:0]               word_addr [LINE_WORDS];
   logic [OW-1:0]             out_idx [LINE_WORDS];
   logic [LINE_WORDS-1:0]     in_out, in_in, wr_mem, wr_io;
   logic [32*LINE_WORDS-1:0]  rd_line;
   logic                      unused_sw;

   assign req_ready_o = rst_ni && (state_q == IDLE);
   assign rsp_valid_o = (state_q == RESP);
   assign rsp_data_o  = rsp_data_q;
   assign rsp_err_o   = rsp_err_q;
   assign accept      = req_valid_i && req_ready_o;
   assign access      = (state_q == BUSY) && (cnt_q == '0);
   assign in_range    = base_q < MEM_WORDS;
   assign unused_sw   = ^sw_sync_q[31:17];

   for (genvar k = 0; k < NUM_IO_OUT; k++) begin : g_io_out
      assign io_out_o[32*k +: 32] = io_out_q[k];
   end

   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept)        state_d = BUSY;
         BUSY:    if (cnt_q == '0)   state_d = RESP;
         RESP:    if (rsp_ready_i)   state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   // Per-word decode of the registered line: region, write enables and read mux.
   always_comb begin
      rd_line = '0;
      wr_err  = 1'b0;
      wr_mem  = '0;
      wr_io   = '0;
      in_out  = '0;
      in_in   = '0;
      for (int i = 0; i < LINE_WORDS; i++) begin
         word_addr[i] = base_q + 32'(i);
         out_idx[i]   = OW'(word_addr[i] - IO_OUT_BASE);
         in_out[i]    = (word_addr[i] >= IO_OUT_BASE) && (word_addr[i] < IO_OUT_BASE + NUM_IO_OUT);
         in_in[i]     = (word_addr[i] >= IO_IN_BASE) && (word_addr[i] < IO_IN_END);
         if (in_range) begin
            if (we_q && wmask_q[i]) begin
               if (in_in[i]) begin
                  wr_err = 1'b1;
               end else begin
                  wr_mem[i] = 1'b1;
                  wr_io[i]  = in_out[i];
               end
            end
            if (in_in[i])
               rd_line[32*i +: 32] = {15'b0, sw_sync_q[16:0]};
            else if (in_out[i])
               rd_line[32*i +: 32] = io_out_q[out_idx[i]];
            else
               rd_line[32*i +: 32] = mem[word_addr[i][AW-1:0]];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         base_q     <= '0;
         wdata_q    <= '0;
         wmask_q    <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         for (int k = 0; k < NUM_IO_OUT; k++) io_out_q[k] <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q   <= CW'(LATENCY - 1);
            we_q    <= req_we_i;
            base_q  <= req_addr_i & ALIGN_MASK;
            wdata_q <= req_wdata_i;
            wmask_q <= req_wmask_i;
         end else if (state_q == BUSY && cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
         end
         if (access) begin
            rsp_data_q <= we_q ? '0 : rd_line;
            rsp_err_q  <= !in_range || wr_err;
            for (int i = 0; i < LINE_WORDS; i++)
               if (wr_io[i]) io_out_q[out_idx[i]] <= wdata_q[32*i +: 32];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         sw_meta_q <= io_sw_i;
         sw_sync_q <= sw_meta_q;
      end
   end

   // NOTE: the array is deliberately not reset; a reset mid-request leaves it untouched
   // because the async state reset drops the access strobe before the next edge.
   always_ff @(posedge clk_i) begin
      if (access) begin
         for (int i = 0; i < LINE_WORDS; i++)
            if (wr_mem[i]) mem[word_addr[i][AW-1:0]] <= wdata_q[32*i +: 32];
      end
   end

endmodule

// File: tb/tb_lsu_line_mem.sv
// Directed bench for lsu_line_mem: a vector table of line requests plus hand-written
// sequences for reset, response back-pressure and reset during an outstanding write.
module tb_lsu_line_mem;

   localparam int LAT = 4;

   typedef logic [127:0] line_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      line_t       wdata;
      logic [3:0]  mask;
      line_t       exp_data;
      logic        exp_err;
   } vec_t;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          req_valid_i = 1'b0;
   logic          req_ready_o;
   logic          req_we_i = 1'b0;
   logic [31:0]   req_addr_i = '0;
   line_t         req_wdata_i = '0;
   logic [3:0]    req_wmask_i = '0;
   logic          rsp_valid_o;
   logic          rsp_ready_i = 1'b0;
   line_t         rsp_data_o;
   logic          rsp_err_o;
   logic [31:0]   io_sw_i = 32'hABC1_FFFF;
   logic [351:0]  io_out_o;

   int n_pass = 0;
   int n_total = 0;

   lsu_line_mem #(
      .LINE_WORDS(4), .MEM_WORDS(512), .LATENCY(LAT),
      .IO_OUT_BASE(256), .IO_IN_BASE(320), .IO_IN_END(384), .NUM_IO_OUT(11)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wmask_i(req_wmask_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
      .rsp_err_o(rsp_err_o), .io_sw_i(io_sw_i), .io_out_o(io_out_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic line_t ln(logic [31:0] w0, logic [31:0] w1, logic [31:0] w2, logic [31:0] w3);
      return {w3, w2, w1, w0};
   endfunction

   function automatic vec_t v(logic we, logic [31:0] a, line_t wd, logic [3:0] m, line_t ed, logic ee);
      vec_t r;
      r.we = we; r.addr = a; r.wdata = wd; r.mask = m; r.exp_data = ed; r.exp_err = ee;
      return r;
   endfunction

   // One full request/response; request inputs are scrambled after accept, and the
   // response is held for 'stall' cycles with stability checks before consumption.
   task automatic run_req(input logic we, input logic [31:0] addr, input line_t wdata,
                          input logic [3:0] mask, input int stall,
                          output line_t data, output logic err, output int lat);
      @(negedge clk_i);
      check("req_ready_idle", req_ready_o, 1'b1);
      req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr;
      req_wdata_i = wdata; req_wmask_i = mask;
      @(posedge clk_i);
      @(negedge clk_i);
      req_valid_i = 1'b0; req_we_i = ~we; req_addr_i = $urandom;
      req_wdata_i = {4{$urandom}}; req_wmask_i = 4'hF;
      lat = 0;
      while (!rsp_valid_o && lat < 50) begin
         @(posedge clk_i);
         @(negedge clk_i);
         lat++;
      end
      data = rsp_data_o;
      err  = rsp_err_o;
      for (int c = 0; c < stall; c++) begin
         @(posedge clk_i);
         @(negedge clk_i);
         check("stall_valid", rsp_valid_o, 1'b1);
         check("stall_data", rsp_data_o, data);
         check("stall_err", rsp_err_o, err);
         check("stall_req_ready", req_ready_o, 1'b0);
      end
      rsp_ready_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      check("ready_after_rsp", req_ready_o, 1'b1);
      check("valid_after_rsp", rsp_valid_o, 1'b0);
   endtask

   initial begin
      vec_t        vecs[20];
      line_t       data;
      logic        err;
      int          lat;
      int          seen;
      logic [31:0] exp_io[11];

      vecs[0]  = v(1, 8,   ln(32'h11, 32'h22, 32'h33, 32'h44), 4'b1111, '0, 0);
      vecs[1]  = v(0, 8,   '0, 4'b0000, ln(32'h11, 32'h22, 32'h33, 32'h44), 0);
      vecs[2]  = v(1, 8,   ln(32'hA0, 32'hA1, 32'hA2, 32'hA3), 4'b0101, '0, 0);
      vecs[3]  = v(0, 8,   '0, 4'b0000, ln(32'hA0, 32'h22, 32'hA2, 32'h44), 0);
      vecs[4]  = v(1, 9,   ln(32'hF0, 32'hF1, 32'hF2, 32'hF3), 4'b1000, '0, 0);
      vecs[5]  = v(0, 11,  '0, 4'b0000, ln(32'hA0, 32'h22, 32'hA2, 32'hF3), 0);
      vecs[6]  = v(1, 258, ln(32'h7, 32'h8, 32'h9, 32'hA), 4'b1111, '0, 0);
      vecs[7]  = v(0, 256, '0, 4'b0000, ln(32'h7, 32'h8, 32'h9, 32'hA), 0);
      vecs[8]  = v(1, 264, ln(32'hB, 32'hC, 32'hD, 32'hE), 4'b1111, '0, 0);
      vecs[9]  = v(0, 264, '0, 4'b0000, ln(32'hB, 32'hC, 32'hD, 32'hE), 0);
      vecs[10] = v(1, 320, ln(32'h1, 32'h2, 32'h3, 32'h4), 4'b1111, '0, 1);
      vecs[11] = v(0, 320, '0, 4'b0000, ln(32'h1FFFF, 32'h1FFFF, 32'h1FFFF, 32'h1FFFF), 0);
      vecs[12] = v(1, 380, ln(32'h1, 32'h2, 32'h3, 32'h4), 4'b1111, '0, 1);
      vecs[13] = v(1, 384, ln(32'h5, 32'h6, 32'h7, 32'h8), 4'b1111, '0, 0);
      vecs[14] = v(0, 384, '0, 4'b0000, ln(32'h5, 32'h6, 32'h7, 32'h8), 0);
      vecs[15] = v(1, 508, ln(32'h1, 32'h2, 32'h3, 32'h4), 4'b1111, '0, 0);
      vecs[16] = v(0, 511, '0, 4'b0000, ln(32'h1, 32'h2, 32'h3, 32'h4), 0);
      vecs[17] = v(0, 512, '0, 4'b0000, '0, 1);
      vecs[18] = v(0, 600, '0, 4'b0000, '0, 1);
      vecs[19] = v(1, 600, ln(32'h5, 32'h6, 32'h7, 32'h8), 4'b1111, '0, 1);

      exp_io = '{32'h7, 32'h8, 32'h9, 32'hA, 32'h0, 32'h0, 32'h0, 32'h0, 32'hB, 32'hC, 32'hD};

      // Reset state
      repeat (3) @(negedge clk_i);
      check("rst_req_ready", req_ready_o, 1'b0);
      check("rst_rsp_valid", rsp_valid_o, 1'b0);
      check("rst_rsp_data", rsp_data_o, '0);
      check("rst_rsp_err", rsp_err_o, 1'b0);
      check("rst_io_out", io_out_o[127:0] | io_out_o[255:128] | {32'h0, io_out_o[351:256]}, '0);
      rst_ni = 1'b1;

      // First read: latency only, the array content is undefined
      run_req(1'b0, 32'd0, '0, 4'b0000, 0, data, err, lat);
      check("read0_latency", lat, LAT);
      check("read0_err", err, 1'b0);

      for (int i = 0; i < 20; i++) begin
         run_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mask, 0, data, err, lat);
         check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
         check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
         check($sformatf("vec%0d_latency", i), lat, LAT);
      end

      for (int k = 0; k < 11; k++)
         check($sformatf("io_out_reg%0d", k), io_out_o[32*k +: 32], exp_io[k]);

      // Response back-pressure for 10 cycles
      run_req(1'b0, 32'd8, '0, 4'b0000, 10, data, err, lat);
      check("stall_read_data", data, ln(32'hA0, 32'h22, 32'hA2, 32'hF3));
      check("stall_read_err", err, 1'b0);

      // Reset during BUSY of a write aborts it
      run_req(1'b1, 32'd16, ln(32'h1, 32'h2, 32'h3, 32'h4), 4'b1111, 0, data, err, lat);
      @(negedge clk_i);
      req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'd16;
      req_wdata_i = ln(32'h9, 32'h9, 32'h9, 32'h9); req_wmask_i = 4'b1111;
      @(posedge clk_i);
      @(negedge clk_i);
      req_valid_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      check("midrst_req_ready", req_ready_o, 1'b0);
      check("midrst_rsp_valid", rsp_valid_o, 1'b0);
      check("midrst_rsp_data", rsp_data_o, '0);
      check("midrst_io_reg0", io_out_o[31:0], 32'h0);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      seen = 0;
      for (int c = 0; c < LAT + 4; c++) begin
         @(negedge clk_i);
         if (rsp_valid_o) seen++;
      end
      check("midrst_no_response", seen, 0);
      run_req(1'b0, 32'd16, '0, 4'b0000, 0, data, err, lat);
      check("midrst_readback", data, ln(32'h1, 32'h2, 32'h3, 32'h4));
      check("midrst_readback_err", err, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/lsu_line_mem.md
Name: lsu_line_mem

Overview:
- Parametrised line-granular backing memory behind the L2 cache.
- Replaces the single-cycle, always-ready store with a real valid/ready request/response handshake, a configurable access latency and per-word write masks.
- Keeps the memory-mapped peripheral regions: output peripheral registers and a synchronised switch input.
- Serves one cache-line request at a time.

Parameters:
- LINE_WORDS, 4, 32-bit words per line; power of two, at least 1.
- MEM_WORDS, 512, array depth in words; power of two and a multiple of LINE_WORDS.
- LATENCY, 4, cycles from request accept to rsp_valid_o; at least 1.
- IO_OUT_BASE, 256, first word address of the output peripheral region.
- IO_IN_BASE, 320, first word address of the input peripheral region.
- IO_IN_END, 384, first word address past the input region.
- NUM_IO_OUT, 11, number of peripheral output registers: hex0..7, ledr, ledg, lcd.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when req_valid_i && req_ready_o.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  32  word address of the line.
- req_wdata_i  in  32*LINE_WORDS  write line; word i at [32i+31:32i].
- req_wmask_i  in  LINE_WORDS  per-word write enable.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when rsp_valid_o && rsp_ready_i.
- rsp_data_o  out  32*LINE_WORDS  read line, same word ordering as req_wdata_i; all zero for writes.
- rsp_err_o  out  1  error: out of range, or write to the input region.
- io_sw_i  in  32  asynchronous switch input.
- io_out_o  out  32*NUM_IO_OUT  peripheral registers; register k at [32k+31:32k].

Behaviour:
- Reset is asynchronous and active-low.
  - Outputs while rst_ni is low and after release: req_ready_o=0 while in reset, then 1 in IDLE; rsp_valid_o=0; rsp_data_o=0; rsp_err_o=0; io_out_o=0.
  - FSM goes to IDLE, the latency counter clears and the switch synchroniser clears.
  - The memory array is not reset.
- FSM states:
  - IDLE: req_ready_o=1. On accept, register the request fields and go to BUSY with cnt=LATENCY-1.
  - BUSY: req_ready_o=0. Decrement cnt each cycle. When cnt==0, perform the access and go to RESP.
  - RESP: rsp_valid_o=1. Hold rsp_data_o and rsp_err_o stable until rsp_ready_i=1, then go to IDLE.
- Timing:
  - rsp_valid_o rises exactly LATENCY cycles after the accept edge.
  - req_ready_o reasserts the cycle after the response handshake.
  - Minimum request spacing is therefore LATENCY+2 cycles.
- Address handling:
  - The low log2(LINE_WORDS) bits of the address are forced to zero, so the line base is aligned.
  - Word i of the line lives at base+i.
- Write access (at the BUSY to RESP edge):
  - Every word with req_wmask_i[i]=1 is written; masked-off words are untouched.
  - Words inside [IO_OUT_BASE, IO_OUT_BASE+NUM_IO_OUT) update io_out_o register (addr-IO_OUT_BASE).
  - Words inside [IO_IN_BASE, IO_IN_END) are dropped and set rsp_err_o=1.
- Read access:
  - The line is captured into the rsp_data_o register on the same edge.
  - Words in the input region read as {15'b0, sw_sync[16:0]}.
  - Words in the output region read back their io_out_o value.
  - All other words read the array.
- sw_sync is io_sw_i passed through a two-flop synchroniser.
- Out of range (base >= MEM_WORDS): no write takes place, read data is all zero, rsp_err_o=1.
- Input request fields are ignored outside an IDLE accept; the registered copy is used throughout.
- Reset mid-BUSY or mid-RESP aborts the request: no write is performed and no response is produced.
- Read-after-write to the same line returns the new data, since writes complete before their response.

Test Plan:
- Reset then idle → req_ready_o=1, rsp_valid_o=0, io_out_o=0. Read addr 0 with LATENCY=4 → rsp_valid_o rises 4 cycles after accept.
- Write addr 8, wdata words 0x11,0x22,0x33,0x44, mask 4'b1111, then read addr 8 → rsp_data_o[31:0]=0x11 and [127:96]=0x44, rsp_err_o=0.
- Write addr 8, mask 4'b0101, data 0xA0..0xA3 → read returns 0xA0,0x22,0xA2,0x44.
- Write addr 258 (aligned down to 256), words 0x7,0x8,0x9,0xA → io_out_o reg0=0x7 (hex0), reg3=0xA (hex3). Write addr 320 → rsp_err_o=1 and a read of 320 with io_sw_i=0x1FFFF returns 0x1FFFF in every word.
- Hold rsp_ready_i=0 for 10 cycles → rsp_valid_o and rsp_data_o stay stable and req_ready_o stays 0. Read addr 600 → rsp_err_o=1, data 0.
- Assert rst_ni=0 during BUSY of a write to addr 16 → no response; a subsequent read of addr 16 returns the pre-write contents.
